vga_image_scanner: RTL and testbench

Display-side consumer of the GPU read port of the memory stage. Generates 640x480@60 VGA timing and walks a fixed image window in raster order. For each window pixel it drives gpu_address and receives the 8-bit encrypted and decrypted pixel bytes. Selects one byte per frame and emits greyscale RGB with hsync/vsync aligned to the pixel.

---
 rtl/vga_image_scanner.sv | 180 ++++++++++++++++++
 tb/tb_vga_image_scanner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/vga_image_scanner.sv
// rtl/vga_image_scanner.sv - VGA timing generator that scans a fixed image window over the GPU read port
//
// Purpose: walks the frame in raster order, reads one byte per window pixel and
// emits greyscale RGB with syncs aligned through a three-stage pipeline.
// Ports:
//   clk            pixel clock
//   reset          synchronous, active-high
//   display_enable 0 holds the scanner in its reset state
//   image_select   0 = encrypted, 1 = decrypted; latched at each frame wrap
//   encrypted_gpu  byte returned one cycle after gpu_address
//   decrypted_gpu  byte returned one cycle after gpu_address
//   gpu_address    registered read address for the current window pixel
//   hsync, vsync   active-low syncs
//   blank_n        1 during active video
//   rgb_out        {g,g,g}
//   frame_start    one-cycle pulse with output pixel (0,0)
module vga_image_scanner #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned IMG_W     = 256,
  parameter int unsigned IMG_H     = 256,
  parameter int unsigned IMG_X0    = 192,
  parameter int unsigned IMG_Y0    = 112,
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter logic [7:0]  BORDER    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        display_enable,
  input  logic        image_select,
  input  logic [7:0]  encrypted_gpu,
  input  logic [7:0]  decrypted_gpu,
  output logic [31:0] gpu_address,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [23:0] rgb_out,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  // reset and display-off share one clear path
  logic clear;
  assign clear = reset || !display_enable;

  // counter state
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   row_base_q, row_base_d;
  logic          sel_q, sel_d;

  // S1
  logic [31:0] addr_q, addr_d;
  logic        s1_act_q, s1_win_q, s1_hs_q, s1_vs_q, s1_sel_q, s1_fs_q;
  // S2
  logic        s2_act_q, s2_win_q, s2_hs_q, s2_vs_q, s2_sel_q, s2_fs_q;
  // S3
  logic [23:0] rgb_q, rgb_d;
  logic        hsync_q, vsync_q, blank_q, fs_q;

  logic [31:0] h32, v32, h_off, v_off;
  logic        h_last, v_last, active, col_in, row_in, in_win, hs_raw, vs_raw, first_px;
  logic [7:0]  pix_byte;

  assign h32    = 32'(h_q);
  assign v32    = 32'(v_q);
  assign h_off  = h32 - IMG_X0;
  assign v_off  = v32 - IMG_Y0;
  assign h_last = (h32 == H_TOTAL - 1);
  assign v_last = (v32 == V_TOTAL - 1);

  assign active   = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
  assign col_in   = (h32 >= IMG_X0) && (h_off < IMG_W);
  assign row_in   = (v32 >= IMG_Y0) && (v_off < IMG_H);
  assign in_win   = active && col_in && row_in;
  assign hs_raw   = !((h32 >= HS_START) && (h32 < HS_END));
  assign vs_raw   = !((v32 >= VS_START) && (v32 < VS_END));
  assign first_px = (h_q == '0) && (v_q == '0);

  always_comb begin
    h_d        = h_last ? '0 : h_q + HW'(1);
    v_d        = v_q;
    row_base_d = row_base_q;
    sel_d      = sel_q;
    if (h_last) begin
      if (v_last) begin
        v_d        = '0;
        row_base_d = BASE_ADDR;
        // the source is switched only between frames so a frame never mixes images
        sel_d      = image_select;
      end else begin
        v_d = v_q + VW'(1);
        // row base always points at column IMG_X0 of the current line's window row
        if (row_in) row_base_d = row_base_q + IMG_W;
      end
    end
  end

  // outside the window the address is left alone so the memory sees no spurious changes
  assign addr_d = in_win ? row_base_q + h_off : addr_q;

  assign pix_byte = s2_sel_q ? decrypted_gpu : encrypted_gpu;

  always_comb begin
    rgb_d = 24'h0;
    if (s2_act_q) rgb_d = s2_win_q ? {3{pix_byte}} : {3{BORDER}};
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      h_q        <= '0;
      v_q        <= '0;
      row_base_q <= BASE_ADDR;
      sel_q      <= 1'b0;
      addr_q     <= BASE_ADDR;
      s1_act_q   <= 1'b0;
      s1_win_q   <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s1_sel_q   <= 1'b0;
      s1_fs_q    <= 1'b0;
      s2_act_q   <= 1'b0;
      s2_win_q   <= 1'b0;
      s2_hs_q    <= 1'b1;
      s2_vs_q    <= 1'b1;
      s2_sel_q   <= 1'b0;
      s2_fs_q    <= 1'b0;
      rgb_q      <= 24'h0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      blank_q    <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      row_base_q <= row_base_d;
      sel_q      <= sel_d;
      addr_q     <= addr_d;
      s1_act_q   <= active;
      s1_win_q   <= in_win;
      s1_hs_q    <= hs_raw;
      s1_vs_q    <= vs_raw;
      s1_sel_q   <= sel_q;
      s1_fs_q    <= first_px;
      s2_act_q   <= s1_act_q;
      s2_win_q   <= s1_win_q;
      s2_hs_q    <= s1_hs_q;
      s2_vs_q    <= s1_vs_q;
      s2_sel_q   <= s1_sel_q;
      s2_fs_q    <= s1_fs_q;
      rgb_q      <= rgb_d;
      hsync_q    <= s2_hs_q;
      vsync_q    <= s2_vs_q;
      blank_q    <= s2_act_q;
      fs_q       <= s2_fs_q;
    end
  end

  assign gpu_address = addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_q;
  assign rgb_out     = rgb_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_image_scanner.sv
// tb/tb_vga_image_scanner.sv - scoreboard bench for vga_image_scanner on a shortened frame
//
// Horizontal timing is the full 800-clock line; the frame is cut to 22 lines
// with an 8-line window at line 4 so two frames fit in a short run.
module tb_vga_image_scanner;

  localparam int H_ACT = 640, H_TOT = 800, HS_S = 656, HS_E = 752;
  localparam int V_ACT = 16, V_TOT = 22, VS_S = 18, VS_E = 20;
  localparam int X0 = 192, W = 256, Y0 = 4, IH = 8;
  localparam int FRAME = H_TOT * V_TOT;

  typedef logic [27:0] obs_t; // {hsync, vsync, blank_n, frame_start, rgb}
  localparam obs_t IDLE = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

  logic        clk = 1'b0;
  logic        reset, display_enable, image_select;
  logic [7:0]  encrypted_gpu = 8'h0, decrypted_gpu = 8'h0;
  logic [31:0] gpu_address;
  logic        hsync, vsync, blank_n, frame_start;
  logic [23:0] rgb_out;

  always #5 clk = ~clk;

  vga_image_scanner #(
    .V_ACTIVE(16), .V_FP(2), .V_SYNC(2), .V_BP(2), .IMG_H(8), .IMG_Y0(4)
  ) dut (
    .clk(clk), .reset(reset), .display_enable(display_enable),
    .image_select(image_select), .encrypted_gpu(encrypted_gpu),
    .decrypted_gpu(decrypted_gpu), .gpu_address(gpu_address),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .rgb_out(rgb_out),
    .frame_start(frame_start)
  );

  // synchronous-read image memory
  always @(posedge clk) begin
    encrypted_gpu <= gpu_address[7:0];
    decrypted_gpu <= ~gpu_address[7:0];
  end

  obs_t sb_q[$];
  int   n_assert = 0, n_fail = 0;
  int   cyc = 0, mh = 0, mv = 0;
  logic msel = 1'b0;

  function automatic obs_t expect_pixel(int h, int v, logic sel);
    logic        hs, vs, act, win, fs;
    logic [31:0] a;
    logic [7:0]  b;
    logic [23:0] rgb;
    hs  = !(h >= HS_S && h < HS_E);
    vs  = !(v >= VS_S && v < VS_E);
    act = (h < H_ACT) && (v < V_ACT);
    win = act && h >= X0 && h < X0 + W && v >= Y0 && v < Y0 + IH;
    a   = (v - Y0) * W + (h - X0);
    b   = sel ? ~a[7:0] : a[7:0];
    rgb = (act && win) ? {b, b, b} : 24'h0;
    fs  = (h == 0) && (v == 0);
    return {hs, vs, act, fs, rgb};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    logic clr, nsel;
    obs_t e;
    clr  = reset || !display_enable;
    nsel = msel;
    if (!clr) begin
      sb_q.push_back(expect_pixel(mh, mv, msel));
      if (mh == H_TOT - 1 && mv == V_TOT - 1) nsel = image_select;
    end
    @(posedge clk);
    #1;
    if (clr) begin
      chk("idle_out", {4'h0, hsync, vsync, blank_n, frame_start, rgb_out}, {4'h0, IDLE});
      chk("idle_addr", gpu_address, 32'd0);
      mh = 0; mv = 0; msel = 1'b0; cyc = 0;
      sb_q = {IDLE, IDLE};
    end else begin
      e = sb_q.pop_front();
      chk("pixel", {4'h0, hsync, vsync, blank_n, frame_start, rgb_out}, {4'h0, e});
      msel = nsel;
      if (mh == H_TOT - 1) begin
        mh = 0;
        mv = (mv == V_TOT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      cyc++;
    end
  endtask

  task automatic run_to(input int t);
    int guard = 0;
    while (cyc < t && guard < 100000) begin
      tick();
      guard++;
    end
    chk("run_to_reached", cyc, t);
  endtask

  initial begin
    reset = 1'b1; display_enable = 1'b1; image_select = 1'b0;
    repeat (4) tick();
    reset = 1'b0;

    // mid-frame reset at (300,10)
    run_to(10 * H_TOT + 300);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // line timing
    run_to(2);    chk("blank_c2", blank_n, 0);
    run_to(3);    chk("blank_c3", blank_n, 1); chk("fs_c3", frame_start, 1);
    run_to(4);    chk("fs_c4", frame_start, 0);
    run_to(642);  chk("blank_c642", blank_n, 1);
    run_to(643);  chk("blank_c643", blank_n, 0);
    run_to(658);  chk("hs_c658", hsync, 1);
    run_to(659);  chk("hs_c659", hsync, 0);
    run_to(754);  chk("hs_c754", hsync, 0);
    run_to(755);  chk("hs_c755", hsync, 1);
    run_to(1458); chk("hs_c1458", hsync, 1);
    run_to(1459); chk("hs_c1459", hsync, 0);

    // data path, border and blanking
    run_to(2 * H_TOT + 50 + 3);  chk("border_50_2", rgb_out, 24'h000000);
    run_to(2 * H_TOT + 700 + 3); chk("blank_rgb", rgb_out, 24'h000000);
    chk("blank_flag", blank_n, 0);

    // address walk
    run_to(Y0 * H_TOT + 192 + 1);       chk("addr_192_y0", gpu_address, 0);
    run_to(Y0 * H_TOT + 200 + 3);       chk("rgb_200_y0", rgb_out, 24'h080808);
    run_to(Y0 * H_TOT + 447 + 1);       chk("addr_447_y0", gpu_address, 255);
    run_to((Y0 + 1) * H_TOT + 100 + 1); chk("addr_hold", gpu_address, 255);
    run_to((Y0 + 1) * H_TOT + 192 + 1); chk("addr_192_y1", gpu_address, 256);

    // select change mid-frame must not affect frame 0
    run_to(10 * H_TOT);
    image_select = 1'b1;
    run_to(11 * H_TOT + 200 + 3);       chk("rgb_f0_after_sel", rgb_out, 24'h080808);
    run_to(11 * H_TOT + 447 + 1);       chk("addr_last", gpu_address, 2047);

    // frame timing
    run_to(VS_S * H_TOT + 2);           chk("vs_before", vsync, 1);
    run_to(VS_S * H_TOT + 3);           chk("vs_fall", vsync, 0);
    run_to(VS_S * H_TOT + 3 + 1599);    chk("vs_last_low", vsync, 0);
    run_to(VS_S * H_TOT + 3 + 1600);    chk("vs_rise", vsync, 1);
    run_to(FRAME + 2);                  chk("fs_f1_before", frame_start, 0);
    run_to(FRAME + 3);                  chk("fs_f1", frame_start, 1);
    run_to(FRAME + Y0 * H_TOT + 100 + 1); chk("addr_hold_f1", gpu_address, 2047);
    run_to(FRAME + Y0 * H_TOT + 200 + 3); chk("rgb_f1_decrypted", rgb_out, 24'hF7F7F7);
    run_to(2 * FRAME + 10);

    // display off behaves like reset; select latch returns to encrypted
    display_enable = 1'b0;
    repeat (5) tick();
    display_enable = 1'b1;
    run_to(3);                          chk("fs_restart", frame_start, 1);
    run_to(Y0 * H_TOT + 200 + 3);       chk("rgb_restart_enc", rgb_out, 24'h080808);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
